// File: rtl/sequence_generator.sv
// sequence_generator: serialises a captured bit pattern MSB-first, repeated
// back-to-back a programmable number of times.
//
// Ports:
//   clk      - single clock, all state changes on the rising edge
//   reset    - synchronous, active-high reset
//   start    - transfer request, honoured only while idle
//   abort    - terminates an active transfer without a done pulse
//   pattern  - bit pattern; bits [len-1:0] are sent
//   len      - pattern length in bits, legal range 1..PAT_W
//   reps     - repetition count, 0 behaves as 1
//   x        - registered serial data bit
//   x_valid  - registered, high while x carries a pattern bit
//   busy     - registered, high while a transfer is in progress
//   done     - registered one-cycle pulse on normal completion
module sequence_generator #(
    parameter int unsigned PAT_W = 16,
    parameter int unsigned REP_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PAT_W-1:0]       pattern,
    input  logic [$clog2(PAT_W):0] len,
    input  logic [REP_W-1:0]       reps,
    output logic                   x,
    output logic                   x_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned LEN_W = $clog2(PAT_W) + 1;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    // Index of the bit currently on x
    logic [LEN_W-1:0]   idx_q, idx_d;
    // Repetitions remaining, including the one in flight; never wraps
    logic [REP_W-1:0]   rep_q, rep_d;
    logic               x_q, x_d;
    logic               x_valid_q, x_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               len_ok;
    logic [PAT_W-1:0]   start_shift;
    logic [PAT_W-1:0]   next_shift;
    logic [PAT_W-1:0]   reload_shift;

    assign len_ok = (len != '0) && (len <= LEN_W'(PAT_W));

    // Variable bit selects done as shifts so any PAT_W works without index-width issues
    assign start_shift  = pattern >> (len - LEN_W'(1));
    assign next_shift   = pat_q >> (idx_q - LEN_W'(1));
    assign reload_shift = pat_q >> (len_q - LEN_W'(1));

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        x_d       = x_q;
        x_valid_d = x_valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                x_d       = 1'b0;
                x_valid_d = 1'b0;
                busy_d    = 1'b0;
                // abort in idle suppresses a simultaneous start
                if (start && !abort && len_ok) begin
                    pat_d     = pattern;
                    len_d     = len;
                    idx_d     = len - LEN_W'(1);
                    rep_d     = (reps == '0) ? REP_W'(1) : reps;
                    x_d       = start_shift[0];
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = StSend;
                end
            end
            StSend: begin
                if (abort) begin
                    state_d   = StIdle;
                    x_d       = 1'b0;
                    x_valid_d = 1'b0;
                    busy_d    = 1'b0;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - LEN_W'(1);
                    x_d   = next_shift[0];
                end else if (rep_q > REP_W'(1)) begin
                    // wrap straight back to the MSB, no gap cycle
                    rep_d = rep_q - REP_W'(1);
                    idx_d = len_q - LEN_W'(1);
                    x_d   = reload_shift[0];
                end else begin
                    state_d   = StIdle;
                    x_d       = 1'b0;
                    x_valid_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                x_d       = 1'b0;
                x_valid_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pat_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rep_q     <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rep_q     <= rep_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboarded bench for sequence_generator: the stimulus side pushes the
// expected per-cycle output stream, a negedge monitor pops and compares.
module tb_sequence_generator;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic [3:0]  reps;
    logic        x;
    logic        x_valid;
    logic        busy;
    logic        done;

    sequence_generator #(
        .PAT_W(16),
        .REP_W(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .pattern(pattern),
        .len    (len),
        .reps   (reps),
        .x      (x),
        .x_valid(x_valid),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = data bit, 1 = done cycle, 2 = silent end (abort/reset)
    typedef struct {
        int   kind;
        logic b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   in_xfer = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: outputs as {x, x_valid, busy, done}
    always @(negedge clk) begin
        if (mon_en) begin
            if (!in_xfer && !x_valid && !done) begin
                chk("idle", {28'd0, x, x_valid, busy, done}, 32'd0);
            end else if (q.size() == 0) begin
                chk("unexpected_output", {28'd0, x, x_valid, busy, done}, 32'd0);
                in_xfer = 1'b0;
            end else begin
                exp_t e;
                e = q.pop_front();
                in_xfer = 1'b1;
                case (e.kind)
                    0: chk("data_bit", {28'd0, x, x_valid, busy, done}, {28'd0, e.b, 3'b110});
                    1: begin
                        chk("done_cycle", {28'd0, x, x_valid, busy, done}, 32'd1);
                        in_xfer = 1'b0;
                    end
                    default: begin
                        chk("silent_end", {28'd0, x, x_valid, busy, done}, 32'd0);
                        in_xfer = 1'b0;
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs changing while busy, including start, must be ignored
    task automatic noise();
        start   = 1'($urandom_range(0, 1));
        pattern = 16'($urandom);
        len     = 5'($urandom_range(0, 31));
        reps    = 4'($urandom);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            start   = 1'b0;
            pattern = 16'($urandom);
            tick();
        end
    endtask

    // cut > 0: number of bits shown before abort (cut_kind 0) or reset (1)
    task automatic xfer(input logic [15:0] p, input int l, input int r,
                        input int cut, input int cut_kind);
        int n;
        int shown;
        n       = l * ((r == 0) ? 1 : r);
        start   = 1'b1;
        abort   = 1'b0;
        pattern = p;
        len     = 5'(l);
        reps    = 4'(r);
        if (l < 1 || l > 16) begin
            tick();
            start = 1'b0;
            return;
        end
        shown = (cut > 0) ? cut : n;
        for (int i = 0; i < shown; i++) begin
            exp_t e;
            e.kind = 0;
            e.b    = p[l - 1 - (i % l)];
            q.push_back(e);
        end
        begin
            exp_t e;
            e.kind = (cut > 0) ? 2 : 1;
            e.b    = 1'b0;
            q.push_back(e);
        end
        tick();
        for (int i = 1; i < shown; i++) begin
            noise();
            tick();
        end
        noise();
        if (cut > 0) begin
            if (cut_kind == 0) abort = 1'b1;
            else reset = 1'b1;
        end
        tick();
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;
        repeat (3) tick();
        chk("reset_state", {28'd0, x, x_valid, busy, done}, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Start on the first edge after reset release
        xfer(16'h000D, 4, 1, 0, 0);
        idle(1);
        xfer(16'h0005, 3, 3, 0, 0);
        xfer(16'h0005, 3, 0, 0, 0);
        xfer(16'h8001, 16, 1, 0, 0);
        // Started in the done cycle of the previous transfer
        xfer(16'h00A5, 8, 1, 0, 0);
        idle(2);
        xfer(16'h00A5, 8, 1, 3, 0);
        xfer(16'h1234, 0, 1, 0, 0);
        idle(1);
        xfer(16'hFFFF, 17, 2, 0, 0);
        idle(1);
        // abort beats start in idle
        start   = 1'b1;
        abort   = 1'b1;
        pattern = 16'h000F;
        len     = 5'd4;
        reps    = 4'd1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        idle(2);
        xfer(16'hBEEF, 16, 2, 5, 1);
        xfer(16'h0003, 2, 15, 0, 0);
        xfer(16'h0001, 1, 5, 0, 0);
        xfer(16'hFFFE, 1, 3, 0, 0);
        idle(1);

        for (int t = 0; t < 150; t++) begin
            logic [15:0] p;
            int l;
            int r;
            int n;
            int cut;
            int kind;
            int sel;
            p = 16'($urandom);
            if ($urandom_range(0, 9) == 0) l = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 31);
            else l = $urandom_range(1, 16);
            r    = $urandom_range(0, 15);
            n    = l * ((r == 0) ? 1 : r);
            cut  = 0;
            kind = 0;
            sel  = $urandom_range(0, 19);
            if (l >= 1 && l <= 16 && sel < 4) begin
                cut  = $urandom_range(1, n);
                kind = (sel == 0) ? 1 : 0;
            end
            xfer(p, l, r, cut, kind);
            idle($urandom_range(0, 3));
        end

        idle(5);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter PAT_W, default 16, maximum pattern length in bits (range 2..32).
REQ-002 Parameter REP_W, default 4, width of the repetition-count input.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to transmit; sampled every rising edge.
REQ-006 abort  input  1  terminate a transfer in progress.
REQ-007 pattern  input  PAT_W  bit pattern to send; bits [len-1:0] are used.
REQ-008 len  input  $clog2(PAT_W)+1  pattern length in bits; legal range 1..PAT_W.
REQ-009 reps  input  REP_W  number of back-to-back repetitions; 0 is treated as 1.
REQ-010 x  output  1  registered serial data bit.
REQ-011 x_valid  output  1  registered; high when x carries a pattern bit.
REQ-012 busy  output  1  registered; high while a transfer is in progress.
REQ-013 done  output  1  registered; one-cycle pulse on normal completion.

Function
REQ-014 The FSM SHALL have two states: IDLE and SEND.
REQ-015 In IDLE, the block SHALL hold x=0, x_valid=0 and busy=0.
REQ-016 In IDLE, start=1 with legal len SHALL capture pattern, len and reps at that edge and enter SEND.
REQ-017 The capturing edge SHALL also drive x<=pattern[len-1], x_valid<=1 and busy<=1, giving zero added latency after acceptance.
REQ-018 In IDLE, start=1 with len=0 or len>PAT_W SHALL be ignored: state stays IDLE and no done pulse is issued.
REQ-019 Bit order SHALL be MSB-first within the len field: pattern[len-1] down to pattern[0].
REQ-020 SEND SHALL emit exactly one bit per cycle for len*max(reps,1) consecutive cycles with x_valid=1 throughout.
REQ-021 No gap cycle SHALL occur between repetitions; bit pattern[len-1] directly follows pattern[0].
REQ-022 The edge after the last bit SHALL set x<=0, x_valid<=0, busy<=0 and done<=1 (one cycle), and return to IDLE.
REQ-023 done SHALL be 0 in every other cycle.
REQ-024 start is accepted in any cycle where busy=0, including the done cycle; the minimum gap between transfers is therefore one cycle.
REQ-025 start while busy=1 SHALL be ignored, and changes on pattern, len or reps SHALL NOT affect the active transfer.
REQ-026 abort=1 in SEND SHALL, at that edge, clear x, x_valid and busy and return to IDLE with no done pulse.
REQ-027 abort and start both high in IDLE: abort SHALL win and start SHALL be ignored.
REQ-028 The bit-index counter SHALL be $clog2(PAT_W)+1 bits wide.
REQ-029 The repetition counter SHALL be REP_W bits wide and SHALL NOT wrap; reps=2^REP_W-1 sends exactly that many repetitions.
REQ-030 len=1 SHALL send pattern[0] reps times, one bit per cycle.

Reset
REQ-031 reset=1 SHALL, at the next edge, force state IDLE and x=0, x_valid=0, busy=0, done=0, and clear all internal registers.
REQ-032 reset SHALL take priority over start and abort.
REQ-033 reset during SEND SHALL end the transfer without a done pulse.
REQ-034 After reset deasserts, start SHALL be accepted on the first edge.

Verification
REQ-035 pattern=16'h000D, len=4, reps=1 -> x=1,1,0,1 on 4 consecutive cycles with x_valid=1; done=1 in the 5th cycle; busy=0 then.
REQ-036 pattern=16'h0005, len=3, reps=3 -> x=1,0,1,1,0,1,1,0,1 contiguous (9 cycles); single done pulse; reps=0 with the same pattern -> 1,0,1 only.
REQ-037 pattern=16'h8001, len=16, reps=1 -> x=1, then fourteen 0s, then 1; done in cycle 17; a new start in the done cycle -> first bit appears in the following cycle.
REQ-038 Transfer of pattern=8'hA5, len=8; start with pattern=16'hFFFF at cycle 3 -> ignored; output is 1,0,1,0,0,1,0,1 unchanged.
REQ-039 abort at the 3rd bit of an 8-bit transfer -> x_valid=0 next cycle, done never asserted; start with len=0 -> no response.
REQ-040 reset asserted at bit 5 of a 16-bit transfer -> all outputs 0 at the next edge, no done; start one cycle after reset release -> normal transfer.
